// File: rtl/rrat_free_return_if.sv
// rrat_free_return_if
//   Bundles the ROB commit port, the flush request, the free-list enqueue
//   port and the status outputs of rrat_free_return.
//   master : ROB / free-list / frontend side (drives commit and flush)
//   slave  : rrat_free_return itself
//   Signals:
//     commit_valid/commit_rd/commit_pd/commit_ready - ROB commit handshake
//     flush_in                                      - flush request pulse
//     fl_clear_out/fl_enqueue_out/fl_wdata_out      - free-list control
//     rrat_map_out                                  - flattened committed map
//     busy_out/err_out                              - rebuild / error status
interface rrat_free_return_if #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned ARCH_W    = $clog2(ARCH_REGS),
    parameter int unsigned PHYS_W    = $clog2(PHYS_REGS)
);
    logic                        commit_valid;
    logic [ARCH_W-1:0]           commit_rd;
    logic [PHYS_W-1:0]           commit_pd;
    logic                        commit_ready;
    logic                        flush_in;
    logic                        fl_clear_out;
    logic                        fl_enqueue_out;
    logic [PHYS_W-1:0]           fl_wdata_out;
    logic [ARCH_REGS*PHYS_W-1:0] rrat_map_out;
    logic                        busy_out;
    logic                        err_out;

    modport master (
        output commit_valid, commit_rd, commit_pd, flush_in,
        input  commit_ready, fl_clear_out, fl_enqueue_out, fl_wdata_out,
               rrat_map_out, busy_out, err_out
    );

    modport slave (
        input  commit_valid, commit_rd, commit_pd, flush_in,
        output commit_ready, fl_clear_out, fl_enqueue_out, fl_wdata_out,
               rrat_map_out, busy_out, err_out
    );
endinterface

// File: rtl/rrat_free_return.sv
// rrat_free_return
//   Retirement RAT plus free-list return path. Each accepted commit updates
//   the committed arch->phys map and returns the superseded physical register
//   to the free list one cycle later. A flush clears the free list and then
//   scans all physical registers, enqueueing every one that is not mapped.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : rrat_free_return_if.slave (commit, flush, free-list, status)
//   Optional: define RRAT_CHECK_EN to enable the sticky err_out consistency
//   check (double-mapped or self-replacing physical register on commit).
module rrat_free_return #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned ARCH_W    = $clog2(ARCH_REGS),
    parameter int unsigned PHYS_W    = $clog2(PHYS_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    rrat_free_return_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCAN
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [PHYS_W-1:0]    map_q [ARCH_REGS];
    logic [PHYS_REGS-1:0] mapped_q;
    logic [PHYS_W-1:0]    scan_cnt_q;
    logic                 enq_q;
    logic [PHYS_W-1:0]    wdata_q;

    logic                 commit_fire;
    logic                 commit_upd;
    logic                 flush_take;
    logic                 scan_last;
    logic [PHYS_W-1:0]    old_pd;

    always_comb begin
        commit_fire = bus.commit_valid && (state_q == IDLE);
        commit_upd  = commit_fire && (bus.commit_rd != '0);
        flush_take  = bus.flush_in && (state_q == IDLE);
        scan_last   = (state_q == SCAN) &&
                      (scan_cnt_q == PHYS_W'(PHYS_REGS - 1));
        old_pd      = map_q[bus.commit_rd];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush is only honoured from IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush_take) state_d = CLEAR;
            CLEAR:   state_d = SCAN;
            SCAN:    if (scan_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.commit_ready = 1'b0;
        bus.fl_clear_out = 1'b0;
        bus.busy_out     = 1'b0;
        case (state_q)
            IDLE:  bus.commit_ready = 1'b1;
            CLEAR: begin
                bus.fl_clear_out = 1'b1;
                bus.busy_out     = 1'b1;
            end
            SCAN:  bus.busy_out = 1'b1;
            default: begin
                bus.commit_ready = 1'b0;
            end
        endcase
    end

    // Map, mapped bitmap, scan counter and the registered enqueue port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PHYS_W'(i);
            end
            mapped_q   <= {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
            scan_cnt_q <= '0;
            enq_q      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            enq_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    scan_cnt_q <= '0;
                    if (commit_upd) begin
                        map_q[bus.commit_rd] <= bus.commit_pd;
                        // Clear before set: if pd == old the register stays mapped
                        mapped_q[old_pd]        <= 1'b0;
                        mapped_q[bus.commit_pd] <= 1'b1;
                        // A free issued alongside a flush would land in the
                        // CLEAR cycle and be wiped; the scan re-frees it instead
                        enq_q   <= !flush_take;
                        wdata_q <= old_pd;
                    end
                end
                CLEAR: begin
                    scan_cnt_q <= '0;
                end
                SCAN: begin
                    if (!mapped_q[scan_cnt_q]) begin
                        enq_q   <= 1'b1;
                        wdata_q <= scan_cnt_q;
                    end
                    scan_cnt_q <= scan_cnt_q + PHYS_W'(1);
                end
                default: begin
                    scan_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.fl_enqueue_out = enq_q;
    assign bus.fl_wdata_out   = wdata_q;

    always_comb begin
        bus.rrat_map_out = '0;
        for (int unsigned i = 0; i < ARCH_REGS; i++) begin
            bus.rrat_map_out[i*PHYS_W +: PHYS_W] = map_q[i];
        end
    end

`ifdef RRAT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (commit_upd &&
                     (mapped_q[bus.commit_pd] || (bus.commit_pd == old_pd))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_out = err_q;
`else
    assign bus.err_out = 1'b0;
`endif

endmodule
